// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default byte width and the baud divisor shared with the transmitter.
package uart_pkg;

   localparam int DEFAULT_DATA_W = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      LAUNCH    = ST_LAUNCH,
      WAIT_DONE = ST_WAIT
   } arbState_t;

   localparam int CLK_HZ   = 50_000_000;
   localparam int BAUD     = 115_200;
   localparam int BAUD_DIV = CLK_HZ / BAUD;

   // Width of a requester index; never below one bit so NUM_REQ=1 still builds.
   function automatic int idWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle of the UART TX arbiter.
// master: the arbiter; slave: the requesters plus the TX shifter.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int ID_W    = idWidth(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_busy;
   logic                      tx_done;
   logic                      grant_valid;
   logic [ID_W-1:0]           grant_id;
   logic                      err_timeout;

   modport master (
      input  req_valid, req_data, tx_busy, tx_done,
      output req_ready, tx_start, tx_data, grant_valid, grant_id, err_timeout
   );

   modport slave (
      output req_valid, req_data, tx_busy, tx_done,
      input  req_ready, tx_start, tx_data, grant_valid, grant_id, err_timeout
   );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first valid requester found when
// scanning rrPtr, rrPtr+1, ... with explicit wrap at NUM_REQ.
module uart_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    rrPtr,
   output logic [NUM_REQ-1:0] winOneHot,
   output logic [ID_W-1:0]    winIdx,
   output logic               anyValid
);

   // Scan from the farthest offset back to rrPtr so the nearest valid wins.
   always_comb begin
      int idx;
      idx       = 0;
      winOneHot = '0;
      winIdx    = '0;
      anyValid  = |valid;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rrPtr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (valid[idx]) begin
            winOneHot      = '0;
            winOneHot[idx] = 1'b1;
            winIdx         = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Accepts one byte per grant, pulses tx_start for one cycle and holds the
// byte until tx_done. Optional watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int          NUM_REQ        = 4,
   parameter int          DATA_W         = DEFAULT_DATA_W,
   parameter int          ID_W           = idWidth(NUM_REQ),
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
   input logic               clk,
   input logic               rst_n,
   uart_tx_arbiter_if.master bus
);

   arbState_t          state, stateNext;
   logic [ID_W-1:0]    rrPtr;
   logic [ID_W-1:0]    winIdx;
   logic [ID_W-1:0]    grantId;
   logic [NUM_REQ-1:0] winOneHot;
   logic [NUM_REQ-1:0] reqReady;
   logic [DATA_W-1:0]  txData;
   logic               grantValid;
   logic               anyValid;
   logic               accept;
   logic               releaseGrant;
   logic               errPulse;
   logic               timeoutHit;

   // Pointer to the requester after id, wrapping explicitly for any NUM_REQ.
   function automatic logic [ID_W-1:0] ptrAfter(input logic [ID_W-1:0] id);
      if (int'(id) >= NUM_REQ - 1) return '0;
      return id + 1'b1;
   endfunction

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) picker (
      .valid     (bus.req_valid),
      .rrPtr     (rrPtr),
      .winOneHot (winOneHot),
      .winIdx    (winIdx),
      .anyValid  (anyValid)
   );

   // Next state plus the ready strobe and grant release decisions.
   always_comb begin
      stateNext    = state;
      reqReady     = '0;
      accept       = 1'b0;
      releaseGrant = 1'b0;
      errPulse     = 1'b0;
      unique case (state)
         IDLE: begin
            // No acceptance while reset is held, so ready stays low with it.
            if (rst_n && !bus.tx_busy && anyValid) begin
               reqReady  = winOneHot;
               accept    = 1'b1;
               stateNext = LAUNCH;
            end
         end
         LAUNCH: stateNext = WAIT_DONE;
         WAIT_DONE: begin
            // Completion wins over an expiry in the same cycle.
            if (bus.tx_done) begin
               releaseGrant = 1'b1;
               stateNext    = IDLE;
            end else if (timeoutHit) begin
               releaseGrant = 1'b1;
               errPulse     = 1'b1;
               stateNext    = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // Capture the granted byte and owner; advance the pointer on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPtr      <= '0;
         txData     <= '0;
         grantId    <= '0;
         grantValid <= 1'b0;
      end else begin
         if (accept) begin
            txData     <= bus.req_data[winIdx*DATA_W +: DATA_W];
            grantId    <= winIdx;
            grantValid <= 1'b1;
         end
         if (releaseGrant) begin
            grantValid <= 1'b0;
            rrPtr      <= ptrAfter(grantId);
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0] waitCnt;

   // Watchdog count: cleared while launching, one tick per cycle of waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 waitCnt <= '0;
      else if (state == LAUNCH)   waitCnt <= '0;
      else if (state == WAIT_DONE) waitCnt <= waitCnt + 16'd1;
   end

   assign timeoutHit = (state == WAIT_DONE) && (waitCnt == TIMEOUT_CYCLES);
`else
   logic [15:0] unusedTimeoutLimit;
   assign unusedTimeoutLimit = TIMEOUT_CYCLES;
   assign timeoutHit         = 1'b0;
`endif

   assign bus.req_ready   = reqReady;
   assign bus.tx_start    = (state == LAUNCH);
   assign bus.tx_data     = txData;
   assign bus.grant_valid = grantValid;
   assign bus.grant_id    = grantId;
   assign bus.err_timeout = errPulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter, with a fake
// transmitter and a round-robin reference model kept in the bench.
// Exercises the watchdog when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();
   uart_tx_arbiter_if #(.NUM_REQ(3), .DATA_W(DW), .ID_W(2))  bus3 ();

   uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYCLES(16'd50)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   uart_tx_arbiter #(
      .NUM_REQ(3), .DATA_W(DW), .ID_W(2), .TIMEOUT_CYCLES(16'd50)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   int            nAssert = 0;
   int            nFail   = 0;
   int            modelPtr = 0;
   bit            pend  [N];
   logic [DW-1:0] pdata [N];
   int            waits [N];
   logic [DW-1:0] lastData;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present the pending set of requesters on the bus.
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]          = pend[i];
         bus.req_data[i*DW +: DW]  = pdata[i];
      end
   endtask

   function automatic bit anyPend();
      for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: first pending requester at or after ptr, modulo N.
   function automatic int modelPick(input int ptr);
      for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   // Current cycle is IDLE with tx_busy low: check the accept and the launch.
   task automatic doGrant(output int win, input int expId, input bit strayDone);
      logic [N-1:0] expReady;
      settle();
      win           = modelPick(modelPtr);
      expReady      = '0;
      expReady[win] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(expReady));
      lastData = pdata[win];
      tick();
      pend[win] = 1'b0;
      for (int i = 0; i < N; i++) waits[i] = pend[i] ? waits[i] + 1 : 0;
      drive();
      bus.tx_done = strayDone;
      settle();
      check("tx_start", 32'(bus.tx_start), 32'd1);
      check("tx_data", 32'(bus.tx_data), 32'(lastData));
      check("grant_id", 32'(bus.grant_id), 32'(win));
      check("grant_valid", 32'(bus.grant_valid), 32'd1);
      check("ready_launch", 32'(bus.req_ready), 32'd0);
      if (expId >= 0) check("grant_order", 32'(bus.grant_id), 32'(expId));
   endtask

   // Hold the fake transmitter busy for delay cycles, then pulse tx_done.
   task automatic finishTransfer(input int win, input int delay);
      tick();
      bus.tx_done = 1'b0;
      bus.tx_busy = 1'b1;
      repeat (delay) begin
         settle();
         check("wait_start", 32'(bus.tx_start), 32'd0);
         check("wait_ready", 32'(bus.req_ready), 32'd0);
         check("wait_gvalid", 32'(bus.grant_valid), 32'd1);
         check("wait_data", 32'(bus.tx_data), 32'(lastData));
         tick();
      end
      bus.tx_done = 1'b1;
      bus.tx_busy = 1'b0;
      tick();
      bus.tx_done = 1'b0;
      settle();
      check("done_gvalid", 32'(bus.grant_valid), 32'd0);
      check("done_start", 32'(bus.tx_start), 32'd0);
      modelPtr = (win + 1) % N;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int win;
      int stall;
      bit anyNew;

      for (int i = 0; i < N; i++) begin
         pend[i]  = 1'b0;
         pdata[i] = '0;
         waits[i] = 0;
      end
      bus.tx_busy    = 1'b0;
      bus.tx_done    = 1'b0;
      bus3.req_valid = '0;
      bus3.req_data  = '0;
      bus3.tx_busy   = 1'b0;
      bus3.tx_done   = 1'b0;

      // Reset with a requester already valid: everything stays at zero.
      pend[0]  = 1'b1;
      pdata[0] = 8'hEE;
      drive();
      repeat (3) tick();
      settle();
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_start", 32'(bus.tx_start), 32'd0);
      check("rst_data", 32'(bus.tx_data), 32'd0);
      check("rst_gvalid", 32'(bus.grant_valid), 32'd0);
      check("rst_gid", 32'(bus.grant_id), 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
      pend[0] = 1'b0;
      drive();
      rst_n = 1'b1;
      tick();

      // All four valid, two rounds: strict 0,1,2,3 rotation.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b1;
            pdata[i] = 8'(8'h10 + r * 8'h10 + i);
         end
         drive();
         for (int i = 0; i < N; i++) begin
            doGrant(win, i, 1'b0);
            check("rot_data", 32'(bus.tx_data), 32'(8'h10 + r * 8'h10 + i));
            finishTransfer(win, 3);
         end
      end

      // Single byte from requester 2, done after 20 cycles.
      pend[2]  = 1'b1;
      pdata[2] = 8'hA5;
      drive();
      doGrant(win, 2, 1'b0);
      check("single_data", 32'(bus.tx_data), 32'h0000_00A5);
      finishTransfer(win, 20);

      // Pointer now at 3: with 1 and 3 valid, 3 goes first, then 1.
      pend[1]  = 1'b1; pdata[1] = 8'h51;
      pend[3]  = 1'b1; pdata[3] = 8'h53;
      drive();
      doGrant(win, 3, 1'b0);
      finishTransfer(win, 2);
      doGrant(win, 1, 1'b0);
      finishTransfer(win, 2);

      // Busy transmitter blocks the grant; stray done in IDLE is ignored.
      pend[0]  = 1'b1; pdata[0] = 8'h3C;
      drive();
      bus.tx_busy = 1'b1;
      repeat (3) begin
         settle();
         check("busy_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.tx_done = 1'b1;
      settle();
      check("stray_ready", 32'(bus.req_ready), 32'd0);
      tick();
      bus.tx_done = 1'b0;
      settle();
      check("stray_start", 32'(bus.tx_start), 32'd0);
      check("stray_gvalid", 32'(bus.grant_valid), 32'd0);
      bus.tx_busy = 1'b0;
      doGrant(win, 0, 1'b1);
      finishTransfer(win, 2);

      // Randomized traffic against the reference model, with fairness bound.
      for (int it = 0; it < 30; it++) begin
         anyNew = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i]  = 1'b1;
               pdata[i] = 8'($urandom);
               anyNew   = 1'b1;
            end
         end
         if (!anyPend()) begin
            pend[it % N]  = 1'b1;
            pdata[it % N] = 8'($urandom);
         end
         drive();
         stall = $urandom_range(0, 2);
         bus.tx_busy = (stall != 0);
         repeat (stall) begin
            settle();
            check("rnd_busy_ready", 32'(bus.req_ready), 32'd0);
            tick();
         end
         bus.tx_busy = 1'b0;
         doGrant(win, -1, 1'(it % 2));
         for (int i = 0; i < N; i++)
            if (pend[i]) check("fair_wait", 32'(waits[i] <= N - 1), 32'd1);
         finishTransfer(win, $urandom_range(1, 6));
      end
      for (int r = 0; r < N; r++) begin
         if (anyPend()) begin
            doGrant(win, -1, 1'b0);
            finishTransfer(win, 1);
         end
      end

      // Reset during WAIT_DONE drops the byte; pending ones restart from 0.
      pend[2] = 1'b1; pdata[2] = 8'h77;
      drive();
      doGrant(win, 2, 1'b0);
      tick();
      bus.tx_busy = 1'b1;
      pend[1] = 1'b1; pdata[1] = 8'h61;
      pend[3] = 1'b1; pdata[3] = 8'h63;
      drive();
      settle();
      check("pre_rst_gvalid", 32'(bus.grant_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gvalid", 32'(bus.grant_valid), 32'd0);
      check("mid_rst_data", 32'(bus.tx_data), 32'd0);
      check("mid_rst_gid", 32'(bus.grant_id), 32'd0);
      check("mid_rst_start", 32'(bus.tx_start), 32'd0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      bus.tx_busy = 1'b0;
      modelPtr = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      doGrant(win, 1, 1'b0);
      finishTransfer(win, 2);
      doGrant(win, 3, 1'b0);
      finishTransfer(win, 2);

`ifdef UART_ARB_TIMEOUT_EN
      // No tx_done: error pulse 50 cycles after entering WAIT_DONE.
      pend[0] = 1'b1; pdata[0] = 8'h0F;
      drive();
      doGrant(win, 0, 1'b0);
      tick();
      bus.tx_busy = 1'b1;
      repeat (49) tick();
      settle();
      check("to_early", 32'(bus.err_timeout), 32'd0);
      tick();
      settle();
      check("to_pulse", 32'(bus.err_timeout), 32'd1);
      tick();
      bus.tx_busy = 1'b0;
      settle();
      check("to_after_err", 32'(bus.err_timeout), 32'd0);
      check("to_after_gvalid", 32'(bus.grant_valid), 32'd0);
      modelPtr = (win + 1) % N;

      // tx_done on the expiry cycle wins: no error.
      pend[2] = 1'b1; pdata[2] = 8'h2F;
      drive();
      doGrant(win, 2, 1'b0);
      tick();
      bus.tx_busy = 1'b1;
      repeat (50) tick();
      bus.tx_done = 1'b1;
      bus.tx_busy = 1'b0;
      settle();
      check("to_done_err", 32'(bus.err_timeout), 32'd0);
      tick();
      bus.tx_done = 1'b0;
      settle();
      check("to_done_gvalid", 32'(bus.grant_valid), 32'd0);
      modelPtr = (win + 1) % N;
`else
      // Without the watchdog a long wait never raises the error.
      pend[0] = 1'b1; pdata[0] = 8'h0F;
      drive();
      doGrant(win, 0, 1'b0);
      tick();
      bus.tx_busy = 1'b1;
      repeat (60) begin
         settle();
         check("no_to_err", 32'(bus.err_timeout), 32'd0);
         tick();
      end
      check("no_to_gvalid", 32'(bus.grant_valid), 32'd1);
      bus.tx_done = 1'b1;
      bus.tx_busy = 1'b0;
      tick();
      bus.tx_done = 1'b0;
      settle();
      check("no_to_done", 32'(bus.grant_valid), 32'd0);
      modelPtr = (win + 1) % N;
`endif

      // Three requesters, all streaming: pointer wraps 2 -> 0.
      bus3.req_valid = 3'b111;
      bus3.req_data  = {8'h32, 8'h31, 8'h30};
      for (int i = 0; i < 7; i++) begin
         settle();
         check("n3_ready", 32'(bus3.req_ready), 32'(1 << (i % 3)));
         tick();
         settle();
         check("n3_start", 32'(bus3.tx_start), 32'd1);
         check("n3_id", 32'(bus3.grant_id), 32'(i % 3));
         check("n3_data", 32'(bus3.tx_data), 32'(8'h30 + i % 3));
         tick();
         bus3.tx_done = 1'b1;
         tick();
         bus3.tx_done = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
